// File: rtl/wddl_dual_rail_launch.sv
// Launch/capture stage for a precharged WDDL network: converts words to dual-rail,
// holds them for an evaluate window, forces a precharge window, and checks the returned rails.
module wddl_dual_rail_launch #(
  parameter int WIDTH       = 8,
  parameter int EVAL_CYCLES = 2,
  parameter int PRE_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] dr_t,
  output logic [WIDTH-1:0] dr_f,
  output logic             phase_eval,
  input  logic [WIDTH-1:0] res_t,
  input  logic [WIDTH-1:0] res_f,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             pre_err
);

  localparam int MAX_CYC = (EVAL_CYCLES > PRE_CYCLES) ? EVAL_CYCLES : PRE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] PRE  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pair_bad;
  logic [WIDTH-1:0] pair_residue;

  // A pair is bad when both rails agree; residue is any rail still high after precharge.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pair
    assign pair_bad[gi]     = ~(res_t[gi] ^ res_f[gi]);
    assign pair_residue[gi] = res_t[gi] | res_f[gi];
  end

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dr_t       <= '0;
      dr_f       <= '0;
      phase_eval <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      pre_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      pre_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dr_t       <= in_data;
            dr_f       <= ~in_data;
            phase_eval <= 1'b1;
            cnt        <= CNT_W'(EVAL_CYCLES - 1);
            state      <= EVAL;
          end
        end
        EVAL: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            out_data   <= res_t;
            out_err    <= |pair_bad;
            out_valid  <= 1'b1;
            dr_t       <= '0;
            dr_f       <= '0;
            phase_eval <= 1'b0;
            cnt        <= CNT_W'(PRE_CYCLES - 1);
            state      <= PRE;
          end
        end
        PRE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            pre_err <= |pair_residue;
            state   <= IDLE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a safe precharged idle.
          dr_t       <= '0;
          dr_f       <= '0;
          phase_eval <= 1'b0;
          cnt        <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wddl_dual_rail_launch.md
Name: wddl_dual_rail_launch

Overview:
- Sequential launch/capture stage that sits directly upstream of the WDDL dual-rail gate network. That network is built from precharged AND/OR standard cells.
- Converts single-rail input words to WDDL dual-rail form (true rail = data, false rail = ~data). Drives both rails for a fixed evaluate window, then forces both rails to 0 for a fixed precharge window.
- Captures the network's dual-rail result at the end of evaluation. Checks that every rail pair is complementary during evaluation and that all rails return to 0 after precharge.

Parameters:
- WIDTH, 8, bits per word (number of dual-rail pairs); >= 1
- EVAL_CYCLES, 2, clock cycles the rails hold evaluate values before sampling; >= 1
- PRE_CYCLES, 1, clock cycles both rails are held at 0 before the next launch; >= 1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word offered
- in_ready  output  1  stage can accept a word
- in_data  input  WIDTH  single-rail input word
- dr_t  output  WIDTH  true rails to the WDDL network
- dr_f  output  WIDTH  false rails to the WDDL network
- phase_eval  output  1  1 while rails carry evaluate values, 0 in precharge/idle
- res_t  input  WIDTH  true rails returned from the WDDL network
- res_f  input  WIDTH  false rails returned from the WDDL network
- out_valid  output  1  one-cycle pulse: out_data/out_err valid
- out_data  output  WIDTH  captured res_t word
- out_err  output  1  evaluate error flag, qualified by out_valid
- pre_err  output  1  one-cycle pulse: precharge residue detected

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE
  - dr_t=dr_f=0, phase_eval=0
  - out_valid=0, out_data=0, out_err=0, pre_err=0, counter=0
- Reset mid-operation aborts immediately. The rails return to 0 on the same edge; no out_valid or pre_err is produced for the aborted word.
- in_ready = (state==IDLE) && !rst. This is combinational and the only combinational output. All other outputs are registered.
- States:
  - IDLE: rails 0.
    - in_valid && in_ready at an edge: dr_t<=in_data, dr_f<=~in_data, phase_eval<=1, cnt<=EVAL_CYCLES-1, state<=EVAL.
    - in_valid without ready is ignored (no capture).
  - EVAL: rails held constant.
    - cnt!=0: cnt<=cnt-1.
    - cnt==0: out_data<=res_t; out_err<=|(~(res_t ^ res_f)) (any non-complementary pair); out_valid<=1; dr_t<=0; dr_f<=0; phase_eval<=0; cnt<=PRE_CYCLES-1; state<=PRE.
  - PRE: rails 0.
    - cnt!=0: cnt<=cnt-1.
    - cnt==0: pre_err<=|(res_t | res_f); state<=IDLE.
- out_valid and pre_err are single-cycle pulses; they default to 0 on every edge where they are not set.
- out_data and out_err hold their values until the next sample.
- No output backpressure: the consumer must take out_data in the out_valid cycle.
- Timing:
  - Rails are valid EVAL_CYCLES cycles after the accept edge.
  - out_valid asserts in the cycle after the (EVAL_CYCLES)th edge following accept.
  - in_ready returns EVAL_CYCLES+PRE_CYCLES edges after accept.
  - Throughput: one word per EVAL_CYCLES+PRE_CYCLES+1 cycles.
- WDDL invariant: dr_t & dr_f == 0 in every cycle, every state, including reset. A rail never transitions directly from one evaluate value to another; a precharge to 0 always intervenes.
- Counter width: clog2(max(EVAL_CYCLES, PRE_CYCLES)+1) bits; no wrap possible.

Test Plan:
- Reset, then idle with in_valid=0: dr_t=dr_f=0, in_ready=1, out_valid=0, pre_err=0 indefinitely.
- Defaults, in_data=0xA5 accepted at edge 0, network echoes rails (res=dr):
  - dr_t=0xA5, dr_f=0x5A, phase_eval=1 after edges 0 and 1.
  - out_valid=1 with out_data=0xA5, out_err=0 after edge 2; rails 0.
  - in_ready=1 after edge 3.
- Back-to-back in_valid held high with words 0x00 then 0xFF: second accept occurs exactly 4 cycles after the first. Rails show 0/0 for at least one cycle between words; dr_t&dr_f==0 throughout.
- Network forces res_t=res_f=0x01 during EVAL: out_valid=1, out_err=1, out_data=0x01.
- Network holds res_t bit 3 high during PRE: pre_err pulses for one cycle on the PRE->IDLE edge. The next accept proceeds normally.
- rst asserted one cycle after accept of 0x3C: the next cycle shows dr_t=dr_f=0 and state IDLE. No out_valid or pre_err follows; a fresh word completes normally.
